// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell used as the serial adder's datapath.
module serial_adder_fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder cell plus a carry flop, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    serial_adder_fulladder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Subtraction is a + ~b + 1, so only the loaded B and carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_s     = sub ? ~b : b;
    assign carry_load_s = sub ? 1'b1 : cin;
`else
    assign b_load_s     = b;
    assign carry_load_s = cin;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            RUN:  busy = 1'b1;
            DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Datapath next state: load on accept, shift one bit per RUN cycle, hold otherwise
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load_s;
                    carry_d = carry_load_s;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            RUN: begin
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                sum_sh_d            = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1]   = fa_s;
                carry_d             = fa_c;
                cnt_d               = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
            DONE: cnt_d = cnt_q;
            default: cnt_d = {CW{1'b0}};
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            sum_sh_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result comes straight from flops; stable throughout DONE
    assign sum  = sum_sh_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8), scoreboard driven.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks;
    int errors;
    logic [W:0] sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair, follow it to DONE, optionally stall, then pop.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tcin, input logic tsub, input int hold);
        int lat;
        logic [W:0] exp;
        logic [W:0] res;
        if (tsub) begin
            sb.push_back({1'b0, ta} + {1'b0, ~tb_v} + {{W{1'b0}}, 1'b1});
        end else begin
            sb.push_back({1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tcin});
        end
        @(negedge clk);
        check_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a   = ta;
        b   = tb_v;
        cin = tcin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'h5A;
        b = 8'hC3;
        check_eq("busy_run", {63'd0, busy}, 64'd1);
        check_eq("in_ready_run", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                check_eq("in_ready_busy", {63'd0, in_ready}, 64'd0);
            end
        end
        check_eq("latency", 64'(lat), 64'(W));
        exp = sb.pop_front();
        res = {cout, sum};
        check_eq("result", 64'(res), 64'(exp));
        if (hold > 0) begin
            in_valid = 1'b1;
            a = 8'h11;
            b = 8'h22;
            repeat (hold) begin
                @(negedge clk);
                check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
                check_eq("hold_result", 64'({cout, sum}), 64'(exp));
                check_eq("hold_no_accept", {63'd0, in_ready}, 64'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("in_ready_after_pop", {63'd0, in_ready}, 64'd1);
        check_eq("out_valid_after_pop", {63'd0, out_valid}, 64'd0);
        check_eq("busy_after_pop", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;

        run_txn(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_txn(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_txn(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        run_txn(8'h3C, 8'h42, 1'b0, 1'b0, 0);
        run_txn(8'h80, 8'h80, 1'b1, 1'b0, 5);

        // Abort mid-RUN: result must vanish and block return to idle at once.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h77;
        b = 8'h99;
        cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check_eq("abort_no_pulse", {63'd0, out_valid}, 64'd0);
        end
        run_txn(8'h3C, 8'h42, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b0, i % 3);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_txn(8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_txn(8'h01, 8'h02, 1'b1, 1'b1, 0);
        run_txn(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b1, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
